// File: rtl/plic_gen2.sv
// plic_gen2: APB platform-level interrupt controller with per-source gateways,
// priority/threshold arbitration and claim/complete. Define PLIC_EDGE_EN to add edge-mode sources.
module plic_gen2 #(
    parameter int SRC_NUM = 31,
    parameter int TGT_NUM = 2,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               psel,
    input  logic               penable,
    input  logic [31:0]        paddr,
    input  logic               pwrite,
    input  logic [3:0]         pstrb,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pslverr,
    output logic               pready,
    input  logic [SRC_NUM-1:0] ints,
    output logic [TGT_NUM-1:0] meip
);
    localparam int NW  = SRC_NUM / 32 + 1;
    localparam int PW  = 32 * NW;
    localparam int IDW = $clog2(SRC_NUM + 1);

    // All per-source vectors are indexed by source ID; bit 0 (ID "none") stays 0.
    logic [PRIO_W-1:0]  prio [SRC_NUM+1];
    logic [SRC_NUM:0]   en [TGT_NUM];
    logic [PRIO_W-1:0]  thr [TGT_NUM];
    logic [SRC_NUM:0]   pending, claimed, ints_id, src_set;
    logic [IDW-1:0]     best_id [TGT_NUM];
    logic [PRIO_W-1:0]  best_prio [TGT_NUM];
    logic [IDW-1:0]     nxt_id [TGT_NUM];
    logic [PRIO_W-1:0]  nxt_prio [TGT_NUM];
`ifdef PLIC_EDGE_EN
    logic [SRC_NUM:0]   mode, deferred, ints_d, edge_in, def_set;
`endif

    logic [21:0] a;
    logic [9:0]  f_idx;
    logic [4:0]  f_et, f_ew;
    logic [8:0]  f_ct;
    logic [11:0] f_off;
    logic [31:0] rdata, bm;
    logic        hit, ro, err, wr_go, rd_go;
    logic        sel_prio, sel_en, sel_mode, sel_thr, sel_clm;
    logic        unused_addr;

    assign a           = paddr[21:0];
    assign f_idx       = a[11:2];
    assign f_et        = a[11:7];
    assign f_ew        = a[6:2];
    assign f_ct        = a[20:12];
    assign f_off       = a[11:0];
    assign unused_addr = ^{paddr[31:22], paddr[1:0]};
    assign bm          = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
    assign ints_id     = {ints, 1'b0};

    function automatic logic [31:0] word_of(input logic [PW-1:0] v, input logic [9:0] w);
        word_of = '0;
        for (int k = 0; k < NW; k++)
            if (int'(w) == k) word_of = v[32*k +: 32];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old);
        merge = (old & ~bm) | (pwdata & bm);
    endfunction

`ifdef PLIC_EDGE_EN
    assign edge_in = ints_id & ~ints_d;
    assign src_set = ~pending & ~claimed & ((mode & edge_in) | (~mode & ints_id));
    assign def_set = mode & edge_in & (pending | claimed);
`else
    assign src_set = ints_id & ~pending & ~claimed;
`endif

    always_comb begin
        rdata    = '0;
        hit      = 1'b0;
        ro       = 1'b0;
        sel_prio = 1'b0;
        sel_en   = 1'b0;
        sel_mode = 1'b0;
        sel_thr  = 1'b0;
        sel_clm  = 1'b0;
        if (a[21]) begin
            if (int'(f_ct) < TGT_NUM && (f_off == 12'h000 || f_off == 12'h004)) begin
                hit     = 1'b1;
                sel_thr = (f_off == 12'h000);
                sel_clm = (f_off == 12'h004);
                for (int t = 0; t < TGT_NUM; t++)
                    if (int'(f_ct) == t)
                        rdata = sel_thr ? 32'(thr[t]) : 32'(best_id[t]);
            end
        end else begin
            case (a[20:12])
                9'd0: if (int'(f_idx) <= SRC_NUM) begin
                    hit      = 1'b1;
                    sel_prio = 1'b1;
                    for (int i = 1; i <= SRC_NUM; i++)
                        if (int'(f_idx) == i) rdata = 32'(prio[i]);
                end
                9'd1: if (int'(f_idx) < NW) begin
                    hit   = 1'b1;
                    ro    = 1'b1;
                    rdata = word_of(PW'(pending), f_idx);
                end
                9'd2: if (int'(f_et) < TGT_NUM && int'(f_ew) < NW) begin
                    hit    = 1'b1;
                    sel_en = 1'b1;
                    for (int t = 0; t < TGT_NUM; t++)
                        if (int'(f_et) == t) rdata = word_of(PW'(en[t]), 10'(f_ew));
                end
`ifdef PLIC_EDGE_EN
                9'd3: if (int'(f_idx) < NW) begin
                    hit      = 1'b1;
                    sel_mode = 1'b1;
                    rdata    = word_of(PW'(mode), f_idx);
                end
`endif
                default: ;
            endcase
        end
    end

    assign err     = !hit || (pwrite && ro);
    assign pslverr = pready && err;
    assign prdata  = (pready && !err) ? rdata : '0;
    // Side effects commit on the edge that closes the pready cycle.
    assign wr_go   = psel && penable && pready && pwrite && !err;
    assign rd_go   = psel && penable && pready && !pwrite && !err;

    always_ff @(posedge clk) begin
        if (rst) pready <= 1'b0;
        else     pready <= psel && penable && !pready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= SRC_NUM; i++) prio[i] <= '0;
            for (int t = 0; t < TGT_NUM; t++) begin
                en[t]  <= '0;
                thr[t] <= '0;
            end
            pending <= '0;
            claimed <= '0;
`ifdef PLIC_EDGE_EN
            mode     <= '0;
            deferred <= '0;
            ints_d   <= '0;
`endif
        end else begin
            pending <= pending | src_set;
`ifdef PLIC_EDGE_EN
            ints_d   <= ints_id;
            deferred <= deferred | def_set;
            if (wr_go && sel_mode)
                for (int i = 1; i <= SRC_NUM; i++)
                    if (int'(f_idx) == i / 32 && pstrb[(i % 32) / 8]) mode[i] <= pwdata[i % 32];
`endif
            if (wr_go && sel_prio)
                for (int i = 1; i <= SRC_NUM; i++)
                    if (int'(f_idx) == i) prio[i] <= PRIO_W'(merge(32'(prio[i])));
            for (int t = 0; t < TGT_NUM; t++) begin
                if (wr_go && sel_en && int'(f_et) == t)
                    for (int i = 1; i <= SRC_NUM; i++)
                        if (int'(f_ew) == i / 32 && pstrb[(i % 32) / 8]) en[t][i] <= pwdata[i % 32];
                if (wr_go && sel_thr && int'(f_ct) == t)
                    thr[t] <= PRIO_W'(merge(32'(thr[t])));
                // Complete: ignored unless the ID is claimed and enabled for this target.
                if (wr_go && sel_clm && int'(f_ct) == t)
                    for (int i = 1; i <= SRC_NUM; i++)
                        if (pwdata == 32'(i) && claimed[i] && en[t][i]) begin
                            claimed[i] <= 1'b0;
`ifdef PLIC_EDGE_EN
                            if (deferred[i] || def_set[i]) begin
                                pending[i]  <= 1'b1;
                                deferred[i] <= 1'b0;
                            end
`endif
                        end
                if (rd_go && sel_clm && int'(f_ct) == t)
                    for (int i = 1; i <= SRC_NUM; i++)
                        if (int'(best_id[t]) == i) begin
                            pending[i] <= 1'b0;
                            claimed[i] <= 1'b1;
                        end
            end
        end
    end

    // Highest priority wins; scanning downward with >= leaves the lowest ID on ties.
    always_comb begin
        for (int t = 0; t < TGT_NUM; t++) begin
            nxt_id[t]   = '0;
            nxt_prio[t] = '0;
            for (int i = SRC_NUM; i >= 1; i--)
                if (pending[i] && en[t][i] && prio[i] != '0 && prio[i] >= nxt_prio[t]) begin
                    nxt_id[t]   = IDW'(i);
                    nxt_prio[t] = prio[i];
                end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meip <= '0;
            for (int t = 0; t < TGT_NUM; t++) begin
                best_id[t]   <= '0;
                best_prio[t] <= '0;
            end
        end else begin
            for (int t = 0; t < TGT_NUM; t++) begin
                best_id[t]   <= nxt_id[t];
                best_prio[t] <= nxt_prio[t];
                meip[t]      <= best_prio[t] > thr[t];
            end
        end
    end
endmodule
